// File: rtl/keystream_harness_pkg.sv
// Shared state encoding and parameter defaults for the keystream capture harness.
package keystream_harness_pkg;

    localparam int unsigned DEF_KEY_W          = 80;
    localparam int unsigned DEF_IV_W           = 80;
    localparam int unsigned DEF_BLOCK_W        = 64;
    localparam int unsigned DEF_NUM_BLOCKS     = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;
    localparam int unsigned DEF_CNT_W          = 32;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_RST_UUT  = 3'd1;
    localparam state_t ST_WAIT_BLK = 3'd2;
    localparam state_t ST_DONE     = 3'd3;
    localparam state_t ST_TIMEOUT  = 3'd4;

endpackage

// File: rtl/keystream_harness_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/keystream_harness.sv
// Drives a keystream generator through reset, captures NUM_BLOCKS blocks on rising
// edges of its block-valid level, and measures how many cycles that took.
module keystream_harness
    import keystream_harness_pkg::*;
#(
    parameter int unsigned KEY_W          = DEF_KEY_W,
    parameter int unsigned IV_W           = DEF_IV_W,
    parameter int unsigned BLOCK_W        = DEF_BLOCK_W,
    parameter int unsigned NUM_BLOCKS     = DEF_NUM_BLOCKS,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic [KEY_W-1:0]              key_i,
    input  logic [IV_W-1:0]               iv_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          timeout_o,
    output logic [NUM_BLOCKS*BLOCK_W-1:0] stream_o,
    output logic [CNT_W-1:0]              cycles_o,
    output logic                          uut_rst_o,
    output logic                          uut_next_o,
    output logic [KEY_W-1:0]              uut_key_o,
    output logic [IV_W-1:0]               uut_iv_o,
    input  logic                          uut_end_i,
    input  logic [BLOCK_W-1:0]            uut_block_i
);

    localparam int unsigned IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic             rst_phase;
    logic             end_prev;
    logic [IDX_W-1:0] blk_idx;
    logic [TO_W-1:0]  to_cnt;
    logic             accept;
    logic             in_wait;
    logic             capture;
    logic             expire;

    assign accept  = start_i && ((state == ST_IDLE) || (state == ST_DONE) ||
                                 (state == ST_TIMEOUT));
    assign in_wait = (state == ST_WAIT_BLK);
    assign capture = in_wait && uut_end_i && !end_prev;
    // to_cnt counts the cycles already spent waiting, so this is the last allowed one
    assign expire  = in_wait && !capture && (to_cnt == TO_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                if (start_i) state_nxt = ST_RST_UUT;
            end
            ST_RST_UUT: begin
                if (rst_phase) state_nxt = ST_WAIT_BLK;
            end
            ST_WAIT_BLK: begin
                if (capture && (blk_idx == LAST_IDX)) begin
                    state_nxt = ST_DONE;
                end else if (expire) begin
                    state_nxt = ST_TIMEOUT;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            rst_phase  <= 1'b0;
            end_prev   <= 1'b0;
            blk_idx    <= '0;
            stream_o   <= '0;
            uut_next_o <= 1'b0;
            uut_key_o  <= '0;
            uut_iv_o   <= '0;
        end else begin
            state      <= state_nxt;
            uut_next_o <= 1'b0;
            rst_phase  <= (state == ST_RST_UUT) ? ~rst_phase : 1'b0;
            // Edge history only tracks WAIT_BLK, so a level left high across reset is stale
            end_prev   <= in_wait && uut_end_i;
            if (accept) begin
                uut_key_o <= key_i;
                uut_iv_o  <= iv_i;
                stream_o  <= '0;
                blk_idx   <= '0;
            end
            if (capture) begin
                for (int k = 0; k < NUM_BLOCKS; k++) begin
                    if (blk_idx == IDX_W'(k)) stream_o[k*BLOCK_W +: BLOCK_W] <= uut_block_i;
                end
                if (blk_idx != LAST_IDX) begin
                    blk_idx    <= blk_idx + 1'b1;
                    uut_next_o <= 1'b1;
                end
            end
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .en    (in_wait),
        .count (cycles_o)
    );

    sat_counter #(
        .WIDTH (TO_W)
    ) u_timeout_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept || capture),
        .en    (in_wait),
        .count (to_cnt)
    );

    assign busy_o    = (state == ST_RST_UUT) || (state == ST_WAIT_BLK);
    assign done_o    = (state == ST_DONE) || (state == ST_TIMEOUT);
    assign timeout_o = (state == ST_TIMEOUT);
    assign uut_rst_o = !in_wait;

endmodule

// File: tb/tb_keystream_harness.sv
// Directed bench: behavioural keystream generator models feed two harness instances.
module tb_keystream_harness;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_a, start_b;
    logic [79:0] key, iv;

    logic         busy_a, done_a, to_a, uut_rst_a, next_a, end_a;
    logic [255:0] stream_a;
    logic [31:0]  cycles_a;
    logic [79:0]  key_a, iv_a;
    logic [63:0]  block_a;

    logic         busy_b, done_b, to_b, uut_rst_b, next_b, end_b;
    logic [63:0]  stream_b, block_b;
    logic [2:0]   cycles_b;
    logic [79:0]  key_b, iv_b;

    keystream_harness #(
        .TIMEOUT_CYCLES (16)
    ) dut_a (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_a),
        .key_i       (key),
        .iv_i        (iv),
        .busy_o      (busy_a),
        .done_o      (done_a),
        .timeout_o   (to_a),
        .stream_o    (stream_a),
        .cycles_o    (cycles_a),
        .uut_rst_o   (uut_rst_a),
        .uut_next_o  (next_a),
        .uut_key_o   (key_a),
        .uut_iv_o    (iv_a),
        .uut_end_i   (end_a),
        .uut_block_i (block_a)
    );

    keystream_harness #(
        .NUM_BLOCKS (1),
        .CNT_W      (3)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_b),
        .key_i       (key),
        .iv_i        (iv),
        .busy_o      (busy_b),
        .done_o      (done_b),
        .timeout_o   (to_b),
        .stream_o    (stream_b),
        .cycles_o    (cycles_b),
        .uut_rst_o   (uut_rst_b),
        .uut_next_o  (next_b),
        .uut_key_o   (key_b),
        .uut_iv_o    (iv_b),
        .uut_end_i   (end_b),
        .uut_block_i (block_b)
    );

    int total = 0;
    int bad   = 0;

    // Generator model A: first block after m_first waiting cycles, then m_next after each next.
    int          m_first = 4, m_next = 2, m_cnt = 0, m_idx = 0;
    bit          m_hold = 1'b0, m_force_hi = 1'b0;
    logic [3:0]  m_nib;
    logic [63:0] exp_q[$];

    always @(negedge clk) begin
        if (uut_rst_a) begin
            m_cnt = m_first;
            m_idx = 0;
            end_a = m_force_hi;
        end else if (next_a) begin
            m_cnt = m_next - 1;
            if (!m_hold) end_a = 1'b0;
        end else if (m_cnt > 0) begin
            m_cnt--;
            end_a = (m_cnt == 0);
            if (end_a) begin
                m_nib   = 4'(m_idx + 1);
                block_a = {16{m_nib}};
                exp_q.push_back(block_a);
                m_idx++;
            end
        end
    end

    // Generator model B: slow, one block after ten waiting cycles.
    int b_cnt = 0;
    always @(negedge clk) begin
        if (uut_rst_b) begin
            b_cnt = 10;
            end_b = 1'b0;
        end else if (b_cnt > 0) begin
            b_cnt--;
            end_b = (b_cnt == 0);
        end
    end

    int   next_hi = 0, runs = 0;
    logic busy_prev = 1'b0;
    always begin
        @(posedge clk);
        #1;
        if (next_a) next_hi++;
        if (busy_a && !busy_prev) runs++;
        busy_prev = busy_a;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_a();
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input string tag, input int limit);
        int n = 0;
        while (done_a !== 1'b1 && n < limit) begin
            tick(1);
            n++;
        end
        check({tag, "_done"}, done_a, 1'b1);
    endtask

    task automatic pop_check_a(input string tag, input int n);
        logic [63:0] exp;
        check({tag, "_sb_size"}, exp_q.size(), n);
        for (int k = 0; k < n; k++) begin
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                check($sformatf("%s_blk%0d", tag, k), stream_a[k*64 +: 64], exp);
            end
        end
    endtask

    int r0;
    int nb;

    initial begin
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        key     = 80'h0123_4567_89AB_CDEF_0F1E;
        iv      = 80'hFEDC_BA98_7654_3210_A5A5;
        block_b = 64'hABCD_EF01_2345_6789;
        tick(3);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_timeout", to_a, 1'b0);
        check("rst_uut_rst", uut_rst_a, 1'b1);
        check("rst_stream", stream_a, '0);
        check("rst_cycles", cycles_a, '0);
        check("rst_next", next_a, 1'b0);
        check("rst_key", key_a, '0);
        rst = 1'b0;
        tick(1);

        // Nominal four-block run
        pulse_a();
        check("r1_busy", busy_a, 1'b1);
        check("r1_uut_rst_a", uut_rst_a, 1'b1);
        check("r1_key", key_a, key);
        check("r1_iv", iv_a, iv);
        tick(1);
        check("r1_uut_rst_b", uut_rst_a, 1'b1);
        tick(1);
        check("r1_uut_rst_released", uut_rst_a, 1'b0);
        wait_done_a("r1", 60);
        check("r1_timeout", to_a, 1'b0);
        check("r1_busy_end", busy_a, 1'b0);
        check("r1_cycles", cycles_a, 32'd10);
        check("r1_uut_rst_end", uut_rst_a, 1'b1);
        check("r1_next_pulses", next_hi, 3);
        pop_check_a("r1", 4);

        // start held high; generator holds valid one cycle past next
        m_hold  = 1'b1;
        m_next  = 3;
        r0      = runs;
        start_a = 1'b1;
        tick(1);
        wait_done_a("r2", 80);
        check("r2_single_run", runs - r0, 1);
        check("r2_cycles", cycles_a, 32'd13);
        pop_check_a("r2", 4);
        tick(1);
        check("r2_restart_busy", busy_a, 1'b1);
        check("r2_restart_done", done_a, 1'b0);
        check("r2_restart_stream", stream_a, '0);
        check("r2_restart_cycles", cycles_a, '0);
        start_a = 1'b0;
        wait_done_a("r2b", 80);
        check("r2b_runs", runs - r0, 2);
        check("r2b_cycles", cycles_a, 32'd13);
        pop_check_a("r2b", 4);

        // One block, then the generator stalls past the timeout
        m_hold = 1'b0;
        m_next = 40;
        pulse_a();
        wait_done_a("r3", 80);
        check("r3_timeout", to_a, 1'b1);
        check("r3_cycles", cycles_a, 32'd20);
        check("r3_busy", busy_a, 1'b0);
        check("r3_upper", stream_a[255:64], '0);
        pop_check_a("r3", 1);

        // Generator never produces a block
        m_first = 0;
        pulse_a();
        wait_done_a("r4", 60);
        check("r4_timeout", to_a, 1'b1);
        check("r4_cycles", cycles_a, 32'd16);
        check("r4_stream", stream_a, '0);
        check("r4_uut_rst", uut_rst_a, 1'b1);
        check("r4_sb_empty", exp_q.size(), 0);

        // Reset mid-run with start asserted alongside
        m_first = 4;
        m_next  = 2;
        pulse_a();
        nb = 0;
        while (stream_a[127:64] === 64'h0 && nb < 40) begin
            tick(1);
            nb++;
        end
        check("r5_two_caps", stream_a[127:0], {{16{4'h2}}, {16{4'h1}}});
        rst     = 1'b1;
        start_a = 1'b1;
        tick(1);
        rst     = 1'b0;
        start_a = 1'b0;
        check("r5_busy", busy_a, 1'b0);
        check("r5_done", done_a, 1'b0);
        check("r5_stream", stream_a, '0);
        check("r5_cycles", cycles_a, '0);
        check("r5_uut_rst", uut_rst_a, 1'b1);
        check("r5_next", next_a, 1'b0);
        check("r5_key", key_a, '0);
        tick(1);
        check("r5_start_ignored", busy_a, 1'b0);
        exp_q.delete();

        // Valid level stuck high before start and through generator reset
        m_force_hi = 1'b1;
        key        = 80'hCAFE_F00D_1234_5678_9ABC;
        tick(2);
        pulse_a();
        check("r6_stream_rst_a", stream_a, '0);
        tick(1);
        check("r6_stream_rst_b", stream_a, '0);
        tick(1);
        m_force_hi = 1'b0;
        wait_done_a("r6", 60);
        check("r6_cycles", cycles_a, 32'd10);
        check("r6_key", key_a, key);
        pop_check_a("r6", 4);

        // Narrow cycle counter saturates on a slow generator
        start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
        nb = 0;
        while (done_b !== 1'b1 && nb < 40) begin
            tick(1);
            nb++;
        end
        check("b_done", done_b, 1'b1);
        check("b_timeout", to_b, 1'b0);
        check("b_cycles_sat", cycles_b, 3'd7);
        check("b_stream", stream_b, 64'hABCD_EF01_2345_6789);
        check("b_busy", busy_b, 1'b0);
        check("b_next", next_b, 1'b0);
        check("b_uut_rst", uut_rst_b, 1'b1);
        check("b_key", key_b, key);
        check("b_iv", iv_b, iv);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keystream_harness.md
KEYSTREAM_HARNESS -- requirements
Module: keystream_harness

Interface
REQ-001 Parameters SHALL be: KEY_W, default 80, key width; IV_W, default 80, IV width; BLOCK_W, default 64, UUT block width; NUM_BLOCKS, default 4, blocks per run (>=1); TIMEOUT_CYCLES, default 4096, max wait per block; CNT_W, default 32, cycle-counter width.
REQ-002 clk  in  1  single clock, all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start_i  in  1  run request, sampled each cycle.
REQ-005 key_i  in  KEY_W  key, latched on accepted start.
REQ-006 iv_i  in  IV_W  IV, latched on accepted start.
REQ-007 busy_o, done_o, timeout_o  out  1 each  run in progress / run finished / run aborted.
REQ-008 stream_o  out  NUM_BLOCKS*BLOCK_W  captured keystream.
REQ-009 cycles_o  out  CNT_W  measured UUT cycles.
REQ-010 uut_rst_o, uut_next_o  out  1 each  UUT reset / next-block request.
REQ-011 uut_key_o, uut_iv_o  out  KEY_W, IV_W  latched key and IV to UUT.
REQ-012 uut_end_i, uut_block_i  in  1, BLOCK_W  UUT block-valid level, UUT block.

Function
REQ-013 FSM states SHALL be IDLE, RST_UUT, WAIT_BLK, DONE, TIMEOUT.
REQ-014 start_i SHALL be accepted in IDLE, DONE and TIMEOUT; ignored in RST_UUT and WAIT_BLK.
REQ-015 On accept: latch key/iv, clear stream_o, cycles_o, block index, timeout counter; clear done_o/timeout_o; go to RST_UUT.
REQ-016 RST_UUT SHALL last exactly 2 cycles, then WAIT_BLK.
REQ-017 uut_rst_o SHALL be 1 in every state except WAIT_BLK.
REQ-018 busy_o SHALL be 1 exactly in RST_UUT and WAIT_BLK.
REQ-019 A capture SHALL occur in WAIT_BLK on a cycle where uut_end_i=1 and its registered previous value=0; the registered value is forced to 0 in RST_UUT.
REQ-020 Capture k SHALL write uut_block_i to stream_o[k*BLOCK_W +: BLOCK_W], block 0 in LSBs, visible next cycle.
REQ-021 After capture k<NUM_BLOCKS-1, uut_next_o SHALL pulse high for exactly the following cycle; otherwise uut_next_o=0.
REQ-022 After capture NUM_BLOCKS-1, the FSM SHALL enter DONE; done_o=1 and held until next accepted start or rst.
REQ-023 cycles_o SHALL increment every WAIT_BLK cycle, including the final capture cycle, saturating at 2^CNT_W-1, and hold in DONE/TIMEOUT.
REQ-024 Per-block timeout counter SHALL clear on each capture and increment otherwise in WAIT_BLK; reaching TIMEOUT_CYCLES without capture SHALL enter TIMEOUT with done_o=1, timeout_o=1, blocks already captured retained.
REQ-025 Capture and timeout on the same cycle: capture wins.
REQ-026 uut_end_i SHALL be ignored outside WAIT_BLK.

Reset
REQ-027 On rst (any state, mid-run included): state IDLE; busy_o, done_o, timeout_o, uut_next_o, stream_o, cycles_o, uut_key_o, uut_iv_o, all counters = 0; uut_rst_o = 1.
REQ-028 start_i asserted together with rst SHALL be ignored.

Structure
REQ-029 Package keystream_harness_pkg SHALL hold the state enum and the parameter defaults.
REQ-030 One sub-module, sat_counter (parametrised width, clear, enable, saturate), SHALL implement cycles_o and the timeout counter.

Verification
REQ-031 Model UUT: end rises 3 cycles after uut_rst_o falls, then 2 cycles after each uut_next_o, blocks 64'h1111..., 64'h2222..., 64'h3333..., 64'h4444... -> done_o=1, timeout_o=0, stream_o={4444..,3333..,2222..,1111..}, cycles_o=10 (4+2+2+2 counting rules per REQ-023: verify against model exact value).
REQ-032 Model never raises end, TIMEOUT_CYCLES=16 -> timeout_o=1, done_o=1 after 16 WAIT_BLK cycles, stream_o=0, uut_rst_o=1.
REQ-033 rst asserted after 2 captures -> next cycle IDLE, stream_o=0, busy_o=0, uut_rst_o=1; fresh start completes normally.
REQ-034 start_i held high throughout a run -> single run only; restart only once in DONE.
REQ-035 CNT_W=3 with slow model (end after 10 cycles, NUM_BLOCKS=1) -> cycles_o=7 saturated.
REQ-036 uut_end_i held high before start and through RST_UUT -> first capture only on a fresh rising edge in WAIT_BLK.
